// File: rtl/snek_ctrl.sv
// Snake game controller: direction capture, step timing, wall/eat detection, food placement.
// Optional macro SNEK_SPEEDUP_EN shortens the step period as the score rises.
module snek_ctrl #(
  parameter int MOVE_DIV = 8,
  parameter int MAXLEN   = 16,
  parameter int FOOD_H0  = 20,
  parameter int FOOD_V0  = 11
) (
  input  logic       frame_clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic       start,
  input  logic [4:0] head_h,
  input  logic [4:0] head_v,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  output logic [2:0] dir,
  output logic       run,
  output logic       grow_flag,
  output logic       food_loc,
  output logic [7:0] score,
  output logic       dead
);

  localparam int LW = $clog2(MAXLEN + 1);

  typedef enum logic [1:0] {IDLE, PLAY, DEAD} state_t;

  state_t        state, state_nxt;
  logic [1:0]    dir_req;
  logic [7:0]    cnt;
  logic [7:0]    period;
  logic [LW-1:0] len;
  logic [4:0]    food_h, food_v;
  logic          food_valid;
  logic [15:0]   lfsr;

  logic          step_due, wall, eat;
  logic [4:0]    nh, nv;
  logic          btn_hit, btn_rev;
  logic [1:0]    btn_dir;
  logic          accept;
  logic [10:0]   fx0, fy0;

`ifdef SNEK_SPEEDUP_EN
  // Every 4 points shave a cycle off the step period, floor of 2.
  always_comb begin
    if ({2'b00, score[7:2]} + 8'd2 >= 8'(MOVE_DIV)) period = 8'd2;
    else                                            period = 8'(MOVE_DIV) - {2'b00, score[7:2]};
  end
`else
  assign period = 8'(MOVE_DIV);
`endif

  assign step_due = (state == PLAY) && (cnt >= period - 8'd1);

  always_comb begin
    nh   = head_h;
    nv   = head_v;
    wall = 1'b0;
    case (dir_req)
      2'd0:    begin nh = head_h - 5'd1; wall = (head_h == 5'd0);  end
      2'd1:    begin nh = head_h + 5'd1; wall = (head_h == 5'd31); end
      2'd2:    begin nv = head_v + 5'd1; wall = (head_v == 5'd23); end
      default: begin nv = head_v - 5'd1; wall = (head_v == 5'd0);  end
    endcase
  end

  assign eat = food_valid && (nh == food_h) && (nv == food_v);

  // Left > right > down > up; reversal judged against the committed direction.
  assign btn_hit = |btn;
  always_comb begin
    if      (btn[0]) btn_dir = 2'd0;
    else if (btn[1]) btn_dir = 2'd1;
    else if (btn[2]) btn_dir = 2'd2;
    else             btn_dir = 2'd3;
  end
  assign btn_rev = ({1'b0, btn_dir ^ 2'b01} == dir);

  assign accept = !food_valid && (lfsr[9:5] <= 5'd23) &&
                  !((lfsr[4:0] == head_h) && (lfsr[9:5] == head_v));

  assign fx0 = 11'(food_h) * 11'd20;
  assign fy0 = 11'(food_v) * 11'd20;
  assign food_loc = food_valid &&
                    ({1'b0, hpos} > fx0) && ({1'b0, hpos} < fx0 + 11'd20) &&
                    ({1'b0, vpos} > fy0) && ({1'b0, vpos} < fy0 + 11'd20);

  assign dead = (state == DEAD);

  always_ff @(posedge frame_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PLAY;
      PLAY:    if (step_due && wall) state_nxt = DEAD;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (reset) begin
      dir        <= 3'd1;
      dir_req    <= 2'd1;
      run        <= 1'b0;
      grow_flag  <= 1'b0;
      score      <= 8'd0;
      len        <= LW'(1);
      cnt        <= 8'd0;
      food_h     <= 5'(FOOD_H0);
      food_v     <= 5'(FOOD_V0);
      food_valid <= 1'b1;
      lfsr       <= 16'hACE1;
    end else begin
      lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      run       <= 1'b0;
      grow_flag <= 1'b0;
      if (state == PLAY) begin
        if (btn_hit && !btn_rev) dir_req <= btn_dir;
        if (step_due) begin
          cnt <= 8'd0;
          if (!wall) begin
            run <= 1'b1;
            dir <= {1'b0, dir_req};
            if (eat) begin
              if (score != 8'hFF) score <= score + 8'd1;
              if (len < LW'(MAXLEN)) begin
                len       <= len + LW'(1);
                grow_flag <= 1'b1;
              end
              food_valid <= 1'b0;
            end
          end
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
      if (accept) begin
        food_h     <= lfsr[4:0];
        food_v     <= lfsr[9:5];
        food_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_snek_ctrl.sv
// Bench for snek_ctrl: food-window table, directed game scenarios, randomized play vs a game model.
module tb_snek_ctrl;
  localparam int MOVE_DIV = 8;
  localparam int MAXLEN   = 16;

  logic       frame_clk = 1'b0;
  logic       reset = 1'b1, start = 1'b0;
  logic [3:0] btn = '0;
  logic [4:0] head_h = 5'd15, head_v = 5'd11;
  logic [9:0] hpos = '0, vpos = '0;
  logic [2:0] dir;
  logic       run, grow_flag, food_loc, dead;
  logic [7:0] score;

  snek_ctrl #(.MOVE_DIV(MOVE_DIV), .MAXLEN(MAXLEN), .FOOD_H0(20), .FOOD_V0(11)) dut (
    .frame_clk(frame_clk), .reset(reset), .btn(btn), .start(start),
    .head_h(head_h), .head_v(head_v), .hpos(hpos), .vpos(vpos),
    .dir(dir), .run(run), .grow_flag(grow_flag), .food_loc(food_loc),
    .score(score), .dead(dead));

  initial forever #5 frame_clk = ~frame_clk;

  int checks = 0, errors = 0;

  // game model: 0 idle, 1 playing, 2 dead
  int          m_st, m_dir, m_req, m_score, m_len, m_cnt, m_fh, m_fv;
  bit          m_fvalid, m_run, m_grow;
  logic [15:0] m_lfsr;

  typedef struct { logic [9:0] h; logic [9:0] v; bit exp; } fvec_t;
  fvec_t fv_tab[10];

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int m_period();
`ifdef SNEK_SPEEDUP_EN
    int p = MOVE_DIV - m_score / 4;
    return (p < 2) ? 2 : p;
`else
    return MOVE_DIV;
`endif
  endfunction

  function automatic bit m_food_px();
    int x0 = m_fh * 20, y0 = m_fv * 20;
    int h = int'(hpos), v = int'(vpos);
    return m_fvalid && h > x0 && h < x0 + 20 && v > y0 && v < y0 + 20;
  endfunction

  function automatic bit reverse_of(int a, int b);
    return (a == 0 && b == 1) || (a == 1 && b == 0) || (a == 2 && b == 3) || (a == 3 && b == 2);
  endfunction

  task automatic model_step();
    int nh, nv, b, old_dir, old_req, ch, cv;
    bit relocate;
    if (reset) begin
      m_st = 0; m_dir = 1; m_req = 1; m_score = 0; m_len = 1; m_cnt = 0;
      m_fh = 20; m_fv = 11; m_fvalid = 1; m_run = 0; m_grow = 0; m_lfsr = 16'hACE1;
      return;
    end
    ch = int'(m_lfsr) % 32;
    cv = (int'(m_lfsr) / 32) % 32;
    relocate = !m_fvalid && cv <= 23 && !(ch == int'(head_h) && cv == int'(head_v));
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    m_run = 0; m_grow = 0;
    if (m_st == 0) begin
      if (start) m_st = 1;
    end else if (m_st == 1) begin
      old_dir = m_dir; old_req = m_req;
      if (m_cnt + 1 >= m_period()) begin
        m_cnt = 0;
        nh = int'(head_h) + (old_req == 1) - (old_req == 0);
        nv = int'(head_v) + (old_req == 2) - (old_req == 3);
        if (nh < 0 || nh > 31 || nv < 0 || nv > 23) m_st = 2;
        else begin
          m_run = 1; m_dir = old_req;
          if (m_fvalid && nh == m_fh && nv == m_fv) begin
            if (m_score < 255) m_score++;
            if (m_len < MAXLEN) begin m_len++; m_grow = 1; end
            m_fvalid = 0;
          end
        end
      end else m_cnt++;
      b = -1;
      for (int i = 3; i >= 0; i--) if (btn[i]) b = i;
      if (b >= 0 && !reverse_of(b, old_dir)) m_req = b;
    end
    if (relocate) begin m_fh = ch; m_fv = cv; m_fvalid = 1; end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    model_step();
    #1;
    chk("run", run, m_run);
    chk("grow_flag", grow_flag, m_grow);
    chk("dir", dir, m_dir);
    chk("score", score, m_score);
    chk("dead", dead, m_st == 2);
    chk("food_loc", food_loc, m_food_px());
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; btn = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Ticks until the model predicts a step pulse; returns tick count, -1 on timeout.
  task automatic wait_run(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (m_run) begin n = i; return; end
    end
    errors++;
    $display("FAIL wait_run timeout after %0d cycles", limit);
  endtask

  // Places the head next to the current food along an allowed direction and waits for the step.
  task automatic feed_one();
    int d, p, n, sc0;
    int guard = 0;
    while (!m_fvalid && guard < 200) begin tick(); guard++; end
    if (!m_fvalid) begin errors++; $display("FAIL relocation timeout fvalid 0 expected 1"); return; end
    d = m_req;
    if ((d == 0 && m_fh > 30) || (d == 1 && m_fh < 1) || (d == 2 && m_fv < 1) || (d == 3 && m_fv > 22)) begin
      if (d < 2) p = (m_fv >= 1) ? 2 : 3;
      else       p = (m_fh <= 30) ? 0 : 1;
      if (m_cnt + 1 >= m_period()) tick();
      btn = 4'(1 << p);
      tick();
      btn = '0;
      d = m_req;
    end
    head_h = 5'(m_fh + (d == 0) - (d == 1));
    head_v = 5'(m_fv + (d == 3) - (d == 2));
    sc0 = m_score;
    wait_run(40, n);
    if (n > 0 && m_score != sc0) begin
      chk("feed_grow", grow_flag, sc0 < MAXLEN - 1);
      chk("feed_score", score, sc0 + 1);
    end
  endtask

  initial begin
    int n1, n2, g;
    fv_tab[0] = '{10'd401, 10'd221, 1'b1};
    fv_tab[1] = '{10'd400, 10'd230, 1'b0};
    fv_tab[2] = '{10'd419, 10'd239, 1'b1};
    fv_tab[3] = '{10'd420, 10'd230, 1'b0};
    fv_tab[4] = '{10'd410, 10'd220, 1'b0};
    fv_tab[5] = '{10'd410, 10'd240, 1'b0};
    fv_tab[6] = '{10'd410, 10'd230, 1'b1};
    fv_tab[7] = '{10'd0,   10'd0,   1'b0};
    fv_tab[8] = '{10'd1023, 10'd1023, 1'b0};
    fv_tab[9] = '{10'd421, 10'd239, 1'b0};

    do_reset();
    chk("rst_dir", dir, 1);
    chk("rst_run", run, 0);
    chk("rst_grow", grow_flag, 0);
    chk("rst_score", score, 0);
    chk("rst_dead", dead, 0);

    foreach (fv_tab[i]) begin
      hpos = fv_tab[i].h; vpos = fv_tab[i].v;
      #1;
      chk($sformatf("food_win_%0d", i), food_loc, fv_tab[i].exp);
    end

    // Step timing from the start of play
    head_h = 5'd15; head_v = 5'd11;
    start = 1'b1; tick(); start = 1'b0;
    wait_run(20, n1);
    chk("first_pulse_delay", n1, 8);
    chk("first_pulse_dir", dir, 1);
    wait_run(20, n2);
    chk("pulse_gap", n2, 8);

    // Reverse press ignored, perpendicular press accepted
    btn = 4'b0001;
    wait_run(20, n1);
    chk("reverse_ignored_dir", dir, 1);
    btn = 4'b1000; tick(); btn = '0;
    wait_run(20, n1);
    chk("up_dir", dir, 3);

    // Eat at head (19,11) going right
    do_reset();
    head_h = 5'd19; head_v = 5'd11; hpos = 10'd410; vpos = 10'd230;
    start = 1'b1; tick(); start = 1'b0;
    wait_run(20, n1);
    chk("eat_run", run, 1);
    chk("eat_grow", grow_flag, 1);
    chk("eat_score", score, 1);
    chk("eat_food_gone", food_loc, 0);
    g = 0;
    while (!m_fvalid && g < 200) begin tick(); g++; end
    hpos = 10'(m_fh * 20 + 10); vpos = 10'(m_fv * 20 + 10);
    #1;
    chk("new_food_loc", food_loc, 1);

    // Grow up to the length cap, then keep eating without growth
    g = 0;
    while (m_score < MAXLEN + 1 && g < 60) begin feed_one(); g++; end
    chk("cap_score", score, MAXLEN + 1);
    chk("cap_dead", dead, 0);

    // Wall hit on the right edge
    do_reset();
    head_h = 5'd31; head_v = 5'd5;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("wall_run", run, 0);
    chk("wall_dead", dead, 1);
    start = 1'b1; btn = 4'b0100;
    for (int i = 0; i < 20; i++) tick();
    start = 1'b0; btn = '0;
    chk("dead_sticky", dead, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("dead_cleared", dead, 0);

    // Randomized play with a mock body generator following the step strobe
    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      head_h = 5'd15; head_v = 5'd11;
      for (int c = 0; c < 500; c++) begin
        start = ($urandom % 4 == 0);
        btn   = ($urandom % 6 == 0) ? 4'($urandom) : 4'd0;
        reset = ($urandom % 400 == 0);
        if ($urandom % 2 == 0) begin
          hpos = 10'(m_fh * 20 + int'($urandom_range(0, 20)));
          vpos = 10'(m_fv * 20 + int'($urandom_range(0, 20)));
        end else begin
          hpos = 10'($urandom); vpos = 10'($urandom);
        end
        tick();
        if (m_run) begin
          head_h = 5'(int'(head_h) + (m_dir == 1) - (m_dir == 0));
          head_v = 5'(int'(head_v) + (m_dir == 2) - (m_dir == 3));
        end
        if (m_st == 2) break;
      end
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/snek_ctrl.md
SNEK_CTRL -- requirements
Module: snek_ctrl

Interface
REQ-001 SHALL have parameter MOVE_DIV, default 8, frame_clk cycles per snake step (legal 2..255).
REQ-002 SHALL have parameter MAXLEN, default 16, maximum body segments (initial length 1).
REQ-003 SHALL have parameters FOOD_H0 and FOOD_V0, defaults 20 and 11, the initial food cell.
REQ-004 frame_clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 btn  in  4  direction buttons, level-sensitive: [0] left, [1] right, [2] down, [3] up.
REQ-007 start  in  1  level; begins play from IDLE.
REQ-008 head_h, head_v  in  5 each  current head cell from the body generator.
REQ-009 hpos, vpos  in  10 each  current pixel position.
REQ-010 dir  out  3  step direction: 0 h-1, 1 h+1, 2 v+1, 3 v-1.
REQ-011 run  out  1  one-cycle step strobe to the body generator.
REQ-012 grow_flag  out  1  grow request; asserted only together with run.
REQ-013 food_loc  out  1  combinational: pixel lies inside the food cell.
REQ-014 score  out  8  food eaten, saturating at 255.
REQ-015 dead  out  1  high in DEAD state.

Function
REQ-016 SHALL implement states IDLE, PLAY, DEAD; IDLE->PLAY when start=1; PLAY->DEAD on wall hit; DEAD exits only via reset.
REQ-017 Grid: h 0..31, v 0..23; cell = 20 px; food_loc = food_valid & hpos>fh*20 & hpos<(fh+1)*20 & vpos>fv*20 & vpos<(fv+1)*20 (strict, 10-bit+ arithmetic, no overflow).
REQ-018 Direction request: each cycle in PLAY, highest-priority pressed button (left>right>down>up) loads dir_req, unless it is the exact reverse of current dir (0<->1, 2<->3), which is ignored.
REQ-019 Step counter counts frame_clk cycles in PLAY; at terminal count it evaluates dir_req against head_h/head_v and resets to 0.
REQ-020 Wall hit at evaluation: dir_req=0 & head_h=0, =1 & head_h=31, =2 & head_v=23, =3 & head_v=0 -> next cycle enter DEAD, run=0, no step issued.
REQ-021 Otherwise, next cycle: run=1 for exactly one cycle, dir=dir_req, grow_flag=1 iff food_valid and next-head cell equals food cell and len<MAXLEN.
REQ-022 Eat (next head = food, food_valid): score+1 (saturating), len+1 if len<MAXLEN, food_valid<=0; eat at len=MAXLEN scores but grow_flag=0.
REQ-023 Food relocation: while food_valid=0, each cycle candidate h=lfsr[4:0], v=lfsr[9:5]; accept when v<=23 and candidate != head cell; on accept latch food cell, food_valid<=1.
REQ-024 LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1, advances every cycle in every state.
REQ-025 run and grow_flag SHALL be 0 in IDLE and DEAD; dir holds its value in IDLE and DEAD.
REQ-026 Button press and step evaluation in same cycle: evaluation uses dir_req before that cycle's update.

Reset
REQ-027 reset SHALL set: state IDLE, dir=1, dir_req=1, run=0, grow_flag=0, score=0, dead=0, len=1, step counter 0, food cell (FOOD_H0,FOOD_V0), food_valid=1, LFSR=16'hACE1.
REQ-028 Reset SHALL take priority over all events in the same cycle, including a pending step or relocation.

Configuration
REQ-029 Macro SNEK_SPEEDUP_EN defined: step period = max(2, MOVE_DIV - score[7:2]); undefined: step period = MOVE_DIV constant, no speedup logic.

Verification
REQ-030 Reset, start=1, head (15,11), no buttons, MOVE_DIV=8 -> first run pulse with dir=1 eight cycles after entering PLAY; pulses every 8 cycles thereafter.
REQ-031 dir=1, press btn[0] (reverse) -> dir stays 1; press btn[3] -> next run pulse has dir=3.
REQ-032 head (19,11), food (20,11), dir=1 -> run=1 & grow_flag=1 same cycle, score=1, food_valid=0 until new food with v<=23 accepted.
REQ-033 head (31,5), dir=1 at evaluation -> no run pulse, dead=1 next cycle, remains until reset.
REQ-034 len=16, eat food -> grow_flag=0, score increments, food relocates.
REQ-035 SNEK_SPEEDUP_EN defined, score=24, MOVE_DIV=8 -> step period 2 cycles; undefined -> 8 cycles.
